// File: rtl/mem_stage_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage_ctrl_pkg : funct3 and FSM state encodings for the MEM stage. Rev 1.0
// ---------------------------------------------------------------------------
package mem_stage_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_align_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_align_unit : byte enables, store lane replication, alignment and load
// extension for one access.  Rev 1.0
// ---------------------------------------------------------------------------
module mem_align_unit
  import mem_stage_ctrl_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic        i_is_store,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  output logic [31:0] o_load
);

  logic [31:0] w_rsh_b;
  logic [31:0] w_rsh_h;

  assign w_rsh_b = i_rdata >> {i_addr_lo, 3'b000};
  assign w_rsh_h = i_rdata >> {i_addr_lo[1], 4'b0000};

  always_comb begin
    o_be       = 4'b0000;
    o_wdata    = 32'h0;
    o_misalign = 1'b0;
    o_load     = 32'h0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_load  = i_funct3[2] ? {24'h0, w_rsh_b[7:0]}
                              : {{24{w_rsh_b[7]}}, w_rsh_b[7:0]};
      end
      F3_H, F3_HU: begin
        o_be       = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata    = {2{i_wdata[15:0]}};
        o_misalign = i_addr_lo[0];
        o_load     = i_funct3[2] ? {16'h0, w_rsh_h[15:0]}
                                 : {{16{w_rsh_h[15]}}, w_rsh_h[15:0]};
      end
      F3_W: begin
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_misalign = |i_addr_lo;
        o_load     = i_rdata;
      end
      default: o_misalign = 1'b1;
    endcase
    // Unsigned sizes have no store form.
    if (i_is_store && i_funct3[2]) begin
      o_misalign = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage_ctrl : sequences RV32I loads/stores onto a req/ack data bus and
// stalls the pipeline until completion, timeout or misalign reject.  Rev 1.0
// ---------------------------------------------------------------------------
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_i,
  input  logic        mem_write_en_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] store_data_i,
  input  logic [2:0]  funct3_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign_err,
  output logic        bus_err
);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_lo;
  logic [2:0]         r_f3;

  logic               w_access;
  logic               w_issue;
  logic               w_timeout;
  logic [3:0]         w_st_be;
  logic [31:0]        w_st_wdata;
  logic               w_st_mis;
  logic [31:0]        w_st_ext;
  logic [3:0]         w_ld_be;
  logic [31:0]        w_ld_wdata;
  logic               w_ld_mis;
  logic [31:0]        w_ld_ext;
  logic               w_unused_align;

  assign w_access  = mem_read_i | mem_write_en_i;
  assign w_issue   = (r_state == ST_IDLE) && w_access && !w_st_mis;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign stall     = w_issue || (r_state == ST_BUSY);

  // Store path: live EX/MEM fields; a set write flag overrides read.
  mem_align_unit u_align_st (
    .i_addr_lo  (mem_addr_i[1:0]),
    .i_funct3   (funct3_i),
    .i_is_store (mem_write_en_i),
    .i_wdata    (store_data_i),
    .i_rdata    (dmem_rdata),
    .o_be       (w_st_be),
    .o_wdata    (w_st_wdata),
    .o_misalign (w_st_mis),
    .o_load     (w_st_ext)
  );

  // Load path: lane and sign come from the fields latched at issue.
  mem_align_unit u_align_ld (
    .i_addr_lo  (r_lo),
    .i_funct3   (r_f3),
    .i_is_store (1'b0),
    .i_wdata    (32'h0),
    .i_rdata    (dmem_rdata),
    .o_be       (w_ld_be),
    .o_wdata    (w_ld_wdata),
    .o_misalign (w_ld_mis),
    .o_load     (w_ld_ext)
  );

  assign w_unused_align = &{1'b0, w_st_ext, w_ld_be, w_ld_wdata, w_ld_mis};

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_issue) w_next = ST_BUSY;
      ST_BUSY: if (dmem_ack || w_timeout) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_lo         <= 2'b00;
      r_f3         <= 3'b000;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'h0;
      dmem_wdata   <= 32'h0;
      dmem_be      <= 4'b0000;
      load_data    <= 32'h0;
      load_valid   <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      load_valid   <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_access && w_st_mis) begin
            misalign_err <= 1'b1;
          end else if (w_access) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_en_i;
            dmem_addr  <= {mem_addr_i[31:2], 2'b00};
            dmem_be    <= w_st_be;
            dmem_wdata <= mem_write_en_i ? w_st_wdata : 32'h0;
            r_lo       <= mem_addr_i[1:0];
            r_f3       <= funct3_i;
            r_cnt      <= '0;
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) begin
              load_data  <= w_ld_ext;
              load_valid <= 1'b1;
            end
          end else if (w_timeout) begin
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
